// File: rtl/fc_sample_fifo_if.sv
// picosoc iomem bus bundle for fc_sample_fifo: the CPU side drives master, the FIFO page is slave.
interface fc_sample_fifo_if;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;

  modport master (
    output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    input  iomem_ready, iomem_rdata
  );

  modport slave (
    input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    output iomem_ready, iomem_rdata
  );
endinterface

// File: rtl/fc_sample_fifo.sv
// Frequency-counter sample FIFO with sequence numbers, exposed as a picosoc iomem page.
// Optional threshold interrupt enabled by defining FC_SAMPLE_FIFO_IRQ_EN.
module fc_sample_fifo #(
  parameter int          DEPTH    = 4,
  parameter logic [7:0]  PAGE     = 8'h04,
  parameter int          SEQ_BITS = 16
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            meas_valid,
  input  logic [31:0]     meas_ref_sys_cnt,
  input  logic [31:0]     meas_sig_cnt,
  input  logic [31:0]     meas_sig_sys_cnt,
  fc_sample_fifo_if.slave bus,
  output logic            irq
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [31:0]         ref_mem    [DEPTH];
  logic [31:0]         sig_mem    [DEPTH];
  logic [31:0]         sigsys_mem [DEPTH];
  logic [SEQ_BITS-1:0] seq_mem    [DEPTH];

  logic [AW-1:0]       wr_ptr, rd_ptr, wr_addr;
  logic [AW:0]         level;
  logic [7:0]          ovf_cnt;
  logic [SEQ_BITS-1:0] seq;

  logic       sel, wr, ctrl_wr, flush, pop, push, drop, empty, full;
  logic [7:0] offset;
  logic [31:0] rd_val;

  assign offset  = bus.iomem_addr[7:0];
  assign sel     = bus.iomem_valid && !bus.iomem_ready && (bus.iomem_addr[31:24] == PAGE);
  assign wr      = sel && (bus.iomem_wstrb != 4'h0);
  assign ctrl_wr = wr && (offset == 8'h14) && bus.iomem_wstrb[0];
  assign empty   = (level == '0);
  assign full    = (level == FULL_LVL);
  assign flush   = ctrl_wr && bus.iomem_wdata[1];
  assign pop     = ctrl_wr && !bus.iomem_wdata[1] && bus.iomem_wdata[0] && !empty;
  // A flush empties the FIFO first, so a simultaneous sample always lands in slot 0.
  assign push    = meas_valid && (flush || !full || pop);
  assign drop    = meas_valid && full && !pop && !flush;
  assign wr_addr = flush ? '0 : wr_ptr;

  logic unused_bits;
  assign unused_bits = ^{bus.iomem_addr[23:8], bus.iomem_wdata};

`ifdef FC_SAMPLE_FIFO_IRQ_EN
  logic [7:0] irq_thresh;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      irq_thresh <= 8'd1;
      irq        <= 1'b0;
    end else begin
      if (wr && (offset == 8'h18) && bus.iomem_wstrb[0])
        irq_thresh <= bus.iomem_wdata[7:0];
      irq <= (irq_thresh != 8'd0) && (32'(level) >= 32'(irq_thresh));
    end
  end
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    rd_val = '0;
    if (!wr) begin
      case (offset)
        8'h00: rd_val = {14'b0, full, empty, ovf_cnt, 8'(level)};
        8'h04: if (!empty) rd_val = ref_mem[rd_ptr];
        8'h08: if (!empty) rd_val = sig_mem[rd_ptr];
        8'h0c: if (!empty) rd_val = sigsys_mem[rd_ptr];
        8'h10: if (!empty) rd_val = 32'(seq_mem[rd_ptr]);
`ifdef FC_SAMPLE_FIFO_IRQ_EN
        8'h18: rd_val = 32'(irq_thresh);
`endif
        default: rd_val = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ref_mem[wr_addr]    <= meas_ref_sys_cnt;
      sig_mem[wr_addr]    <= meas_sig_cnt;
      sigsys_mem[wr_addr] <= meas_sig_sys_cnt;
      seq_mem[wr_addr]    <= seq;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      level           <= '0;
      ovf_cnt         <= '0;
      seq             <= '0;
      bus.iomem_ready <= 1'b0;
      bus.iomem_rdata <= '0;
    end else begin
      bus.iomem_ready <= sel;
      bus.iomem_rdata <= sel ? rd_val : '0;
      if (meas_valid)
        seq <= seq + 1'b1;
      if (flush) begin
        rd_ptr  <= '0;
        wr_ptr  <= push ? AW'(1) : '0;
        level   <= push ? (AW+1)'(1) : '0;
        ovf_cnt <= '0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + 1'b1;
        if (pop)
          rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)
          level <= level + 1'b1;
        else if (pop && !push)
          level <= level - 1'b1;
        if (drop && (ovf_cnt != 8'hff))
          ovf_cnt <= ovf_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fc_sample_fifo.sv
// Directed bench for fc_sample_fifo: queue-based reference model plus literal register expectations.
module tb_fc_sample_fifo;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        meas_valid = 1'b0;
  logic [31:0] m_ref = '0, m_sig = '0, m_sys = '0;
  logic        irq;

  fc_sample_fifo_if bus();

  fc_sample_fifo #(.DEPTH(DEPTH), .PAGE(8'h04), .SEQ_BITS(16)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .meas_valid       (meas_valid),
    .meas_ref_sys_cnt (m_ref),
    .meas_sig_cnt     (m_sig),
    .meas_sig_sys_cnt (m_sys),
    .bus              (bus.slave),
    .irq              (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] r;
    logic [31:0] s;
    logic [31:0] y;
    logic [15:0] q;
  } entry_t;

  entry_t      mq[$];
  int unsigned m_seq = 0;
  int unsigned m_ovf = 0;
  int unsigned m_thresh = 1;

  int          checks = 0;
  int          errors = 0;
  bit          chk_en = 0;
  logic        exp_ready = 0;
  bit          exp_chk_rd = 0;
  logic [31:0] exp_rdata = '0;
  logic        exp_irq = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_seq = 0;
    m_ovf = 0;
    m_thresh = 1;
  endfunction

  function automatic logic [31:0] model_read(logic [7:0] off);
    int unsigned n;
    n = mq.size();
    case (off)
      8'h00: return 32'(n + m_ovf * 256 + ((n == 0) ? 65536 : 0) + ((n == DEPTH) ? 131072 : 0));
      8'h04: return (n != 0) ? mq[0].r : 32'd0;
      8'h08: return (n != 0) ? mq[0].s : 32'd0;
      8'h0c: return (n != 0) ? mq[0].y : 32'd0;
      8'h10: return (n != 0) ? 32'(mq[0].q) : 32'd0;
`ifdef FC_SAMPLE_FIFO_IRQ_EN
      8'h18: return 32'(m_thresh);
`endif
      default: return 32'd0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("ready", 32'(bus.iomem_ready), 32'(exp_ready));
      if (exp_ready && exp_chk_rd)
        check("rdata", bus.iomem_rdata, exp_rdata);
      check("irq", 32'(irq), 32'(exp_irq));
    end
`ifdef FC_SAMPLE_FIFO_IRQ_EN
    exp_irq = resetn && (m_thresh != 0) && (mq.size() >= m_thresh);
`else
    exp_irq = 1'b0;
`endif
  end

  // One bus/measurement cycle, then one settle cycle so the ack pulse can be observed ending.
  task automatic step(input bit bus_en, input logic [31:0] addr, input logic [3:0] wstrb,
                      input logic [31:0] wdata, input bit meas, input logic [31:0] mr,
                      input logic [31:0] ms, input logic [31:0] my, input bit rst,
                      output logic [31:0] rd);
    bit          acked;
    logic [31:0] exp;
    acked = bus_en && (addr[31:24] == 8'h04) && !rst;
    exp   = model_read(addr[7:0]);
    bus.iomem_valid = bus_en;
    bus.iomem_addr  = addr;
    bus.iomem_wstrb = wstrb;
    bus.iomem_wdata = wdata;
    meas_valid = meas;
    m_ref = mr;
    m_sig = ms;
    m_sys = my;
    resetn = !rst;
    @(posedge clk); #1;
    bus.iomem_valid = 1'b0;
    bus.iomem_wstrb = 4'h0;
    meas_valid = 1'b0;
    resetn = 1'b1;
    if (rst) begin
      model_reset();
    end else begin
      if (acked && wstrb[0] && addr[7:0] == 8'h14) begin
        if (wdata[1]) begin
          mq.delete();
          m_ovf = 0;
        end else if (wdata[0] && mq.size() > 0) begin
          void'(mq.pop_front());
        end
      end
`ifdef FC_SAMPLE_FIFO_IRQ_EN
      if (acked && wstrb[0] && addr[7:0] == 8'h18)
        m_thresh = 32'(wdata[7:0]);
`endif
      if (meas) begin
        if (mq.size() < DEPTH) mq.push_back(entry_t'{mr, ms, my, m_seq[15:0]});
        else if (m_ovf < 255) m_ovf++;
        m_seq++;
      end
    end
    exp_ready  = acked;
    exp_chk_rd = (wstrb == 4'h0);
    exp_rdata  = exp;
    rd = bus.iomem_rdata;
    @(posedge clk); #1;
    exp_ready = 1'b0;
  endtask

  task automatic rd_reg(input logic [7:0] off, output logic [31:0] v);
    step(1, {8'h04, 16'h0, off}, 4'h0, '0, 0, '0, '0, '0, 0, v);
  endtask

  task automatic wr_reg(input logic [7:0] off, input logic [31:0] d);
    logic [31:0] v;
    step(1, {8'h04, 16'h0, off}, 4'hf, d, 0, '0, '0, '0, 0, v);
  endtask

  task automatic push(input logic [31:0] mr, input logic [31:0] ms, input logic [31:0] my);
    logic [31:0] v;
    step(0, '0, 4'h0, '0, 1, mr, ms, my, 0, v);
  endtask

  task automatic do_reset();
    logic [31:0] v;
    step(0, '0, 4'h0, '0, 0, '0, '0, '0, 1, v);
  endtask

  logic [31:0] v;

  initial begin
    bus.iomem_valid = 1'b0;
    bus.iomem_addr  = '0;
    bus.iomem_wstrb = 4'h0;
    bus.iomem_wdata = '0;
    @(posedge clk); #1;
    chk_en = 1;
    @(posedge clk); #1;
    resetn = 1'b1;

    // Reset state
    rd_reg(8'h00, v); check("t1_status", v, 32'h0001_0000);
    rd_reg(8'h04, v); check("t1_head_ref_empty", v, 32'd0);
    rd_reg(8'h1c, v); check("unmapped_read", v, 32'd0);
    step(1, 32'h0500_0000, 4'h0, '0, 0, '0, '0, '0, 0, v);

    // Basic push/read/pop
    for (int i = 0; i < 3; i++) push(100 + i, 10 + i, 200 + i);
    rd_reg(8'h00, v); check("t2_status", v, 32'h0000_0003);
    rd_reg(8'h04, v); check("t2_ref", v, 32'd100);
    rd_reg(8'h08, v); check("t2_sig", v, 32'd10);
    rd_reg(8'h0c, v); check("t2_sigsys", v, 32'd200);
    rd_reg(8'h10, v); check("t2_seq", v, 32'd0);
    wr_reg(8'h14, 32'd1);
    rd_reg(8'h10, v); check("t2_seq_after_pop", v, 32'd1);

    // Overflow and drain
    do_reset();
    for (int i = 0; i < 6; i++) push(i, i + 1, i + 2);
    rd_reg(8'h00, v); check("t3_status", v, 32'h0002_0204);
    for (int i = 0; i < 4; i++) begin
      rd_reg(8'h10, v); check("t3_drain_seq", v, 32'(i));
      wr_reg(8'h14, 32'd1);
    end
    push(7, 8, 9);
    rd_reg(8'h10, v); check("t3_seq_after_drops", v, 32'd6);

    // Full FIFO: pop and push in the same cycle
    do_reset();
    for (int i = 0; i < 4; i++) push(i, i, i);
    step(1, 32'h0400_0014, 4'h1, 32'd1, 1, 32'd50, 32'd51, 32'd52, 0, v);
    rd_reg(8'h00, v); check("t4_status", v, 32'h0002_0004);
    for (int i = 1; i <= 4; i++) begin
      rd_reg(8'h10, v); check("t4_seq", v, 32'(i));
      wr_reg(8'h14, 32'd1);
    end

    // Flush, pop-on-empty, flush with concurrent sample
    do_reset();
    for (int i = 0; i < 9; i++) push(i, i, i);
    wr_reg(8'h14, 32'd1);
    wr_reg(8'h14, 32'd1);
    rd_reg(8'h00, v); check("t5_status_pre", v, 32'h0000_0502);
    wr_reg(8'h14, 32'd3);
    rd_reg(8'h00, v); check("t5_status_flush", v, 32'h0001_0000);
    wr_reg(8'h14, 32'd1);
    rd_reg(8'h00, v); check("t5_pop_empty", v, 32'h0001_0000);
    step(1, 32'h0400_0014, 4'h1, 32'd2, 1, 32'd77, 32'd78, 32'd79, 0, v);
    rd_reg(8'h00, v); check("t5_flush_meas", v, 32'h0000_0001);
    rd_reg(8'h10, v); check("t5_flush_meas_seq", v, 32'd9);

    // Head read while pushing into an empty FIFO sees the old (empty) state
    do_reset();
    step(1, 32'h0400_0004, 4'h0, '0, 1, 32'd33, 32'd34, 32'd35, 0, v);
    check("same_cycle_push_hidden", v, 32'd0);
    rd_reg(8'h04, v); check("push_visible_after", v, 32'd33);

    // Reset with an access pending
    step(1, 32'h0400_0000, 4'h0, '0, 0, '0, '0, '0, 1, v);
    rd_reg(8'h00, v); check("mid_reset_status", v, 32'h0001_0000);
    push(1, 2, 3);
    rd_reg(8'h10, v); check("mid_reset_seq", v, 32'd0);

    // Threshold interrupt
    do_reset();
`ifdef FC_SAMPLE_FIFO_IRQ_EN
    rd_reg(8'h18, v); check("thresh_reset", v, 32'd1);
    wr_reg(8'h18, 32'd2);
    rd_reg(8'h18, v); check("thresh_rw", v, 32'd2);
    push(1, 1, 1);
    check("irq_one", 32'(irq), 32'd0);
    push(2, 2, 2);
    check("irq_two", 32'(irq), 32'd1);
    wr_reg(8'h14, 32'd1);
    check("irq_pop", 32'(irq), 32'd0);
`else
    rd_reg(8'h18, v); check("thresh_reset", v, 32'd0);
    wr_reg(8'h18, 32'd2);
    rd_reg(8'h18, v); check("thresh_rw", v, 32'd0);
    push(1, 1, 1);
    push(2, 2, 2);
    check("irq_two", 32'(irq), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
